// File: rtl/sopc_data_bus_pkg.sv
// Shared definitions for the SoPC data-side interconnect.
//   - bus_state_t : FSM encodings (IDLE / BUSY / DONE)
//   - default slave memory map: RAM, timer, UART, GPIO base/mask pairs
//   - BUS_ERR_DATA: read data returned on a decode miss or timeout
package sopc_data_bus_pkg;

  typedef enum logic [1:0] {
    BUS_IDLE = 2'd0,
    BUS_BUSY = 2'd1,
    BUS_DONE = 2'd2
  } bus_state_t;

  localparam logic [31:0] RAM_BASE   = 32'h0000_0000;
  localparam logic [31:0] RAM_MASK   = 32'hFFFF_0000;
  localparam logic [31:0] TIMER_BASE = 32'h1000_0000;
  localparam logic [31:0] TIMER_MASK = 32'hFFFF_0000;
  localparam logic [31:0] UART_BASE  = 32'h2000_0000;
  localparam logic [31:0] UART_MASK  = 32'hFFFF_0000;
  localparam logic [31:0] GPIO_BASE  = 32'h3000_0000;
  localparam logic [31:0] GPIO_MASK  = 32'hFFFF_0000;

  localparam logic [31:0] BUS_ERR_DATA = 32'h0;

endpackage

// File: rtl/sopc_addr_decoder.sv
// Combinational address decoder for the data-side interconnect.
// Slave i hits when (addr & mask_i) == base_i. Overlapping windows resolve
// to the lowest slave index so that hit is always one-hot (or zero).
// Ports:
//   addr  in  ADDR_W      address to decode
//   hit   out NUM_SLAVES  one-hot selected slave
//   miss  out 1           no slave window matched
module sopc_addr_decoder
  import sopc_data_bus_pkg::*;
#(
  parameter int ADDR_W     = 32,
  parameter int NUM_SLAVES = 4,
  parameter logic [NUM_SLAVES*ADDR_W-1:0] SLAVE_BASE = '0,
  parameter logic [NUM_SLAVES*ADDR_W-1:0] SLAVE_MASK = '0
) (
  input  logic [ADDR_W-1:0]     addr,
  output logic [NUM_SLAVES-1:0] hit,
  output logic                  miss
);

  logic [NUM_SLAVES-1:0] match;

  for (genvar i = 0; i < NUM_SLAVES; i++) begin : g_match
    assign match[i] = ((addr & SLAVE_MASK[i*ADDR_W +: ADDR_W]) ==
                       SLAVE_BASE[i*ADDR_W +: ADDR_W]);
  end

  // Isolate the lowest set bit: lowest index wins on overlap.
  assign hit  = match & (~match + NUM_SLAVES'(1));
  assign miss = ~|match;

endmodule

// File: rtl/sopc_data_bus.sv
// Data-side interconnect between the CPU data port and NUM_SLAVES
// memory-mapped slaves. Decodes the CPU address, runs a stb/ack handshake
// with the selected slave and stalls the CPU until the access finishes.
// Decode misses (and, optionally, timeouts) return a one-cycle bus error.
//
// Optional feature macro: SOPC_BUS_TIMEOUT_EN
//   defined   : a BUSY-cycle counter aborts an unanswered access after
//               TIMEOUT cycles with a bus error.
//   undefined : BUSY waits for an ack indefinitely.
//
// Ports:
//   clk, rst     clock, synchronous active-low reset
//   cpu_ce_i     access request          cpu_we_i   1 = write
//   cpu_addr_i   address                 cpu_sel_i  byte lanes
//   cpu_data_i   write data              cpu_data_o registered read data
//   cpu_stall_o  hold CPU pipeline       bus_err_o  one-cycle error pulse
//   s_addr_o/s_we_o/s_sel_o/s_data_o     shared registered slave request
//   s_stb_o      one-hot registered strobe
//   s_data_i     packed slave read data  s_ack_i    per-slave ack
module sopc_data_bus
  import sopc_data_bus_pkg::*;
#(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int NUM_SLAVES = 4,
  parameter logic [NUM_SLAVES*ADDR_W-1:0] SLAVE_BASE =
    {GPIO_BASE, UART_BASE, TIMER_BASE, RAM_BASE},
  parameter logic [NUM_SLAVES*ADDR_W-1:0] SLAVE_MASK =
    {GPIO_MASK, UART_MASK, TIMER_MASK, RAM_MASK},
  parameter int TIMEOUT    = 255
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         cpu_ce_i,
  input  logic                         cpu_we_i,
  input  logic [ADDR_W-1:0]            cpu_addr_i,
  input  logic [DATA_W/8-1:0]          cpu_sel_i,
  input  logic [DATA_W-1:0]            cpu_data_i,
  output logic [DATA_W-1:0]            cpu_data_o,
  output logic                         cpu_stall_o,
  output logic                         bus_err_o,
  output logic [ADDR_W-1:0]            s_addr_o,
  output logic                         s_we_o,
  output logic [DATA_W/8-1:0]          s_sel_o,
  output logic [DATA_W-1:0]            s_data_o,
  output logic [NUM_SLAVES-1:0]        s_stb_o,
  input  logic [NUM_SLAVES*DATA_W-1:0] s_data_i,
  input  logic [NUM_SLAVES-1:0]        s_ack_i
);

  localparam logic [DATA_W-1:0] ERR_DATA = DATA_W'(BUS_ERR_DATA);

  if (NUM_SLAVES < 1 || NUM_SLAVES > 8 || TIMEOUT < 1) begin : g_bad_param
    $error("sopc_data_bus: NUM_SLAVES must be 1..8 and TIMEOUT >= 1");
  end

  bus_state_t            state, state_nxt;
  logic [NUM_SLAVES-1:0] dec_hit;
  logic                  dec_miss;
  logic                  ack_sel;
  logic                  expire;
  logic [DATA_W-1:0]     rd_mux;

  sopc_addr_decoder #(
    .ADDR_W     (ADDR_W),
    .NUM_SLAVES (NUM_SLAVES),
    .SLAVE_BASE (SLAVE_BASE),
    .SLAVE_MASK (SLAVE_MASK)
  ) u_addr_decoder (
    .addr (cpu_addr_i),
    .hit  (dec_hit),
    .miss (dec_miss)
  );

  // Only the strobed slave may complete the access; stb is zero outside
  // BUSY, so stray acks there are masked as well.
  assign ack_sel = |(s_ack_i & s_stb_o);

  always_comb begin
    rd_mux = '0;
    for (int i = 0; i < NUM_SLAVES; i++) begin
      if (s_stb_o[i]) rd_mux = rd_mux | s_data_i[i*DATA_W +: DATA_W];
    end
  end

`ifdef SOPC_BUS_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT + 1);
  logic [CNT_W-1:0] to_cnt;

  // Held at zero outside BUSY, so it starts from zero on every BUSY entry.
  // to_cnt == k in the (k+1)-th BUSY cycle; expiry fires in the
  // TIMEOUT-th BUSY cycle, so the count reaches TIMEOUT at the abort edge.
  always_ff @(posedge clk) begin
    if (!rst || state != BUS_BUSY) to_cnt <= '0;
    else                           to_cnt <= to_cnt + CNT_W'(1);
  end

  assign expire = (state == BUS_BUSY) && (to_cnt == CNT_W'(TIMEOUT - 1));
`else
  assign expire = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!rst) state <= BUS_IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt   = state;
    cpu_stall_o = 1'b0;
    case (state)
      BUS_IDLE: begin
        cpu_stall_o = cpu_ce_i;
        if (cpu_ce_i) state_nxt = dec_miss ? BUS_DONE : BUS_BUSY;
      end
      BUS_BUSY: begin
        cpu_stall_o = 1'b1;
        if (ack_sel || expire) state_nxt = BUS_DONE;
      end
      BUS_DONE: state_nxt = BUS_IDLE;
      default:  state_nxt = BUS_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      cpu_data_o <= '0;
      bus_err_o  <= 1'b0;
      s_addr_o   <= '0;
      s_we_o     <= 1'b0;
      s_sel_o    <= '0;
      s_data_o   <= '0;
      s_stb_o    <= '0;
    end else begin
      case (state)
        BUS_IDLE: begin
          if (cpu_ce_i) begin
            if (dec_miss) begin
              cpu_data_o <= ERR_DATA;
              bus_err_o  <= 1'b1;
            end else begin
              s_addr_o <= cpu_addr_i;
              s_we_o   <= cpu_we_i;
              s_sel_o  <= cpu_sel_i;
              s_data_o <= cpu_data_i;
              s_stb_o  <= dec_hit;
            end
          end
        end
        BUS_BUSY: begin
          // An ack in the expiry cycle takes priority over the abort.
          if (ack_sel) begin
            if (!s_we_o) cpu_data_o <= rd_mux;
            s_stb_o <= '0;
          end else if (expire) begin
            s_stb_o    <= '0;
            cpu_data_o <= ERR_DATA;
            bus_err_o  <= 1'b1;
          end
        end
        BUS_DONE: bus_err_o <= 1'b0;
        default:  bus_err_o <= 1'b0;
      endcase
    end
  end

endmodule
